// File: rtl/seven_segment_scan_controller.sv
// rtl/seven_segment_scan_controller.sv - 16-bit binary to 4-digit multiplexed 7-segment driver
//
// Converts a strobed 16-bit value to BCD with a shift-add-3 sequence and
// time-multiplexes the four digits of a common-anode display.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high
//   value        in   16  binary value to display
//   value_valid  in   1   one-cycle strobe: capture value
//   busy         out  1   conversion in progress
//   anode        out  4   digit enables, active-low; anode[0] = units
//   cathode      out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
module seven_segment_scan_controller #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        busy,
    output logic [3:0]  anode,
    output logic [7:0]  cathode
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_start;
    logic [15:0]   w_start_val;

    logic [15:0]   r_bin;
    logic [15:0]   r_bcd;
    logic          r_ovf;
    logic [3:0]    r_shift_cnt;
    logic [15:0]   w_bcd_adj;

    logic [15:0]   r_disp_bcd;
    logic          r_disp_ovf;
    logic          r_pend;
    logic [15:0]   r_pend_val;

    logic [CW-1:0] r_refresh;
    logic [1:0]    r_index;
    logic [3:0]    w_digit;
    logic          w_lead_zero;
    logic [7:0]    w_seg;

    // A fresh strobe in IDLE wins over a queued pending value (last strobe wins).
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_val  = value;
        case (r_state)
            S_IDLE: begin
                if (value_valid) begin
                    w_start      = 1'b1;
                    w_start_val  = value;
                    w_state_next = S_SHIFT;
                end else if (r_pend) begin
                    w_start      = 1'b1;
                    w_start_val  = r_pend_val;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_shift_cnt == 4'd15) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign busy = (r_state != S_IDLE);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Four BCD nibbles suffice: values above 9999 only ever show dashes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_shift_cnt <= '0;
            r_disp_bcd  <= '0;
            r_disp_ovf  <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_val  <= '0;
        end else begin
            if (w_start) begin
                r_bin       <= w_start_val;
                r_bcd       <= '0;
                r_ovf       <= (w_start_val > 16'd9999);
                r_shift_cnt <= '0;
            end
            if (r_state == S_SHIFT) begin
                {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
                r_shift_cnt    <= r_shift_cnt + 4'd1;
            end
            if (r_state == S_LOAD) begin
                r_disp_bcd <= r_bcd;
                r_disp_ovf <= r_ovf;
            end
            if (r_state == S_IDLE) begin
                r_pend <= 1'b0;
            end else if (value_valid) begin
                r_pend     <= 1'b1;
                r_pend_val <= value;
            end
        end
    end

    // Leading-zero test covers the digit itself and every digit above it.
    always_comb begin
        w_digit     = r_disp_bcd[{r_index, 2'b00} +: 4];
        w_lead_zero = 1'b0;
        case (r_index)
            2'd3:    w_lead_zero = (r_disp_bcd[15:12] == 4'd0);
            2'd2:    w_lead_zero = (r_disp_bcd[15:8] == 8'd0);
            2'd1:    w_lead_zero = (r_disp_bcd[15:4] == 12'd0);
            default: w_lead_zero = 1'b0;
        endcase
        case (w_digit)
            4'd0:    w_seg = 8'hC0;
            4'd1:    w_seg = 8'hF9;
            4'd2:    w_seg = 8'hA4;
            4'd3:    w_seg = 8'hB0;
            4'd4:    w_seg = 8'h99;
            4'd5:    w_seg = 8'h92;
            4'd6:    w_seg = 8'h82;
            4'd7:    w_seg = 8'hF8;
            4'd8:    w_seg = 8'h80;
            4'd9:    w_seg = 8'h90;
            default: w_seg = 8'hFF;
        endcase
        if (r_disp_ovf) begin
            w_seg = 8'hBF;
        end else if (BLANK_LEADING && w_lead_zero) begin
            w_seg = 8'hFF;
        end
    end

    // Anode and cathode come from the same index in the same edge, so no ghosting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_index   <= 2'd0;
            anode     <= 4'b1111;
            cathode   <= 8'hFF;
        end else begin
            if (r_refresh == CW'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_index   <= r_index + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            anode   <= ~(4'b0001 << r_index);
            cathode <= w_seg;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb/tb_seven_segment_scan_controller.sv - self-checking bench for seven_segment_scan_controller
module tb_seven_segment_scan_controller;
    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'd0;
    logic        value_valid = 1'b0;
    logic        busy_a, busy_b;
    logic [3:0]  anode_a, anode_b;
    logic [7:0]  cath_a, cath_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    seven_segment_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_a (
        .clock(clock), .reset(reset), .value(value), .value_valid(value_valid),
        .busy(busy_a), .anode(anode_a), .cathode(cath_a)
    );

    seven_segment_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_b (
        .clock(clock), .reset(reset), .value(value), .value_valid(value_valid),
        .busy(busy_b), .anode(anode_b), .cathode(cath_b)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Segment pattern from decimal arithmetic on the displayed number.
    function automatic logic [7:0] seg_code(input int val, input int idx, input bit blank);
        int p;
        int d;
        p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        if (val > 9999) return 8'hBF;
        if (blank && idx > 0 && val < p) return 8'hFF;
        d = (val / p) % 10;
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    // Timeline model: a conversion accepted at edge S occupies edges S+1..S+17,
    // the displayed number changes at edge S+17, and the scan steps every DIV edges.
    int         m_edge = 0;
    int         m_start = -1;
    int         m_conv_val = 0;
    bit         m_pend = 1'b0;
    int         m_pend_val = 0;
    int         m_disp = 0;
    int         m_k = 0;
    int         m_idx = 0;
    logic [3:0] e_anode = 4'hF;
    logic [7:0] e_cath_a = 8'hFF;
    logic [7:0] e_cath_b = 8'hFF;
    logic       e_busy = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_edge = 0; m_start = -1; m_pend = 1'b0; m_disp = 0; m_k = 0;
            e_anode = 4'hF; e_cath_a = 8'hFF; e_cath_b = 8'hFF; e_busy = 1'b0;
        end else begin
            m_edge++;
            m_idx = (m_k / DIV) % 4;
            m_k++;
            e_anode  = ~(4'b0001 << m_idx);
            e_cath_a = seg_code(m_disp, m_idx, 1'b1);
            e_cath_b = seg_code(m_disp, m_idx, 1'b0);
            if (m_start >= 0) begin
                if (value_valid) begin
                    m_pend = 1'b1;
                    m_pend_val = int'(value);
                end
                if (m_edge == m_start + 17) begin
                    m_disp  = m_conv_val;
                    m_start = -1;
                end
            end else begin
                if (value_valid) begin
                    m_start = m_edge; m_conv_val = int'(value);
                end else if (m_pend) begin
                    m_start = m_edge; m_conv_val = m_pend_val;
                end
                m_pend = 1'b0;
            end
            e_busy = (m_start >= 0);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy_a",  {15'd0, busy_a},  {15'd0, e_busy});
            chk("busy_b",  {15'd0, busy_b},  {15'd0, e_busy});
            chk("anode_a", {12'd0, anode_a}, {12'd0, e_anode});
            chk("anode_b", {12'd0, anode_b}, {12'd0, e_anode});
            chk("cath_a",  {8'd0, cath_a},   {8'd0, e_cath_a});
            chk("cath_b",  {8'd0, cath_b},   {8'd0, e_cath_b});
        end
    end

    logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] cap_a [4];
    logic [7:0] cap_b [4];

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic strobe(input logic [15:0] v);
        value = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!busy_a) break;
            tick();
        end
        if (i == 100) chk("wait_idle_timeout", 16'd1, 16'd0);
    endtask

    task automatic capture();
        for (int i = 0; i < 4; i++) begin
            cap_a[i] = 8'h00;
            cap_b[i] = 8'h00;
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            for (int j = 0; j < 4; j++) begin
                if (anode_a == an_tbl[j]) cap_a[j] = cath_a;
                if (anode_b == an_tbl[j]) cap_b[j] = cath_b;
            end
        end
        tick();
    endtask

    task automatic chk_digits_a(input string nm, input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0);
        chk({nm, "_d3"}, {8'd0, cap_a[3]}, {8'd0, d3});
        chk({nm, "_d2"}, {8'd0, cap_a[2]}, {8'd0, d2});
        chk({nm, "_d1"}, {8'd0, cap_a[1]}, {8'd0, d1});
        chk({nm, "_d0"}, {8'd0, cap_a[0]}, {8'd0, d0});
    endtask

    initial begin
        int bcnt;
        int v;
        int gap;

        // T2: idle scan after reset
        repeat (3) @(posedge clock);
        #2;
        chk_en = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("t2_anode", {12'd0, anode_a}, {12'd0, an_tbl[i / 4]});
            chk("t2_cath", {8'd0, cath_a}, (i < 4) ? 16'h00C0 : 16'h00FF);
        end
        tick();

        // T1: 488, busy for 17 cycles
        strobe(16'd488);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_a) break;
            bcnt++;
            tick();
        end
        chk("t1_busy_cycles", 16'(bcnt), 16'd17);
        capture();
        chk_digits_a("t1", 8'hFF, 8'h99, 8'h80, 8'h80);

        // T3: overflow, then 9999
        strobe(16'd10000);
        wait_idle();
        capture();
        chk_digits_a("t3_ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        strobe(16'd9999);
        wait_idle();
        capture();
        chk_digits_a("t3_9999", 8'h90, 8'h90, 8'h90, 8'h90);

        // T4: strobes while busy, last one wins
        strobe(16'd1234);
        repeat (4) tick();
        strobe(16'd56);
        repeat (3) tick();
        strobe(16'd789);
        wait_idle();
        capture();
        chk_digits_a("t4_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        wait_idle();
        capture();
        chk_digits_a("t4_789", 8'hFF, 8'hF8, 8'h80, 8'h90);

        // T5: reset mid-conversion
        strobe(16'd4321);
        repeat (7) tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("t5_rst_anode", {12'd0, anode_a}, 16'h000F);
            chk("t5_rst_cath", {8'd0, cath_a}, 16'h00FF);
            chk("t5_rst_busy", {15'd0, busy_a}, 16'd0);
        end
        tick();
        reset = 1'b0;
        tick();
        chk("t5_busy", {15'd0, busy_a}, 16'd0);
        chk("t5_anode", {12'd0, anode_a}, 16'h000E);
        chk("t5_cath", {8'd0, cath_a}, 16'h00C0);

        // T6: blanking on vs off
        strobe(16'd7);
        wait_idle();
        capture();
        chk_digits_a("t6_a", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        chk("t6_b_d3", {8'd0, cap_b[3]}, 16'h00C0);
        chk("t6_b_d2", {8'd0, cap_b[2]}, 16'h00C0);
        chk("t6_b_d1", {8'd0, cap_b[1]}, 16'h00C0);
        chk("t6_b_d0", {8'd0, cap_b[0]}, 16'h00F8);

        // Random strobes, including while busy
        for (int it = 0; it < 60; it++) begin
            case ($urandom % 4)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 9999);
                2: v = $urandom_range(10000, 65535);
                default: v = $urandom_range(0, 999);
            endcase
            strobe(16'(v));
            gap = $urandom_range(0, 30);
            repeat (gap) tick();
        end
        wait_idle();
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
